// File: rtl/game_tick_scheduler_pkg.sv
// Shared constants for the dino game tick sequencer and its consumers
// (obstacles and audio also take their level width from here).
package game_tick_scheduler_pkg;

  localparam int unsigned DEF_DIV_SLOW  = 3;
  localparam int unsigned DEF_ACC_W     = 6;
  localparam int unsigned DEF_BASE_STEP = 32;
  localparam int unsigned DEF_STEP_INC  = 4;
  localparam int unsigned DEF_MAX_LEVEL = 7;
  localparam int unsigned LEVEL_W       = 3;

  // Largest per-frame increment; it must stay below 2**ACC_W so a frame
  // can never produce more than one obstacle tick.
  function automatic int unsigned max_step(input int unsigned base_step,
                                           input int unsigned step_inc,
                                           input int unsigned max_level);
    return base_step + step_inc * max_level;
  endfunction

endpackage

// File: rtl/game_tick_scheduler_tick_divider.sv
// Generic modulo-N pulse divider: one output pulse every N enables, plus a
// copy of that pulse delayed by one cycle.
module game_tick_scheduler_tick_divider #(
  parameter int unsigned N = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic tick_dly
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      tick     <= 1'b0;
      tick_dly <= 1'b0;
    end else begin
      tick_dly <= tick;
      tick     <= 1'b0;
      if (en) begin
        if (cnt == CNT_LAST) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Central tick sequencer: slow player/score tick pair from the frame pulse,
// plus a score-accelerated obstacle tick from a phase accumulator.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned DIV_SLOW  = DEF_DIV_SLOW,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned BASE_STEP = DEF_BASE_STEP,
  parameter int unsigned STEP_INC  = DEF_STEP_INC,
  parameter int unsigned MAX_LEVEL = DEF_MAX_LEVEL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_pulse,
  input  logic               game_start_pulse,
  input  logic               game_frozen,
  input  logic [15:0]        score,
  output logic [1:0]         tick_slow,
  output logic               tick_obstacle,
  output logic [LEVEL_W-1:0] speed_level
);

  localparam int unsigned STEP_W = ACC_W + 1;

  if (max_step(BASE_STEP, STEP_INC, MAX_LEVEL) >= (2 ** ACC_W)) begin : g_step_check
    $error("obstacle step can reach 2**ACC_W: more than one tick per frame");
  end

  logic [ACC_W-1:0]   acc;
  logic [LEVEL_W-1:0] level;
  logic [3:0]         prev_hundreds;
  logic [STEP_W-1:0]  step;
  logic [STEP_W-1:0]  acc_sum;
  logic               hundreds_changed;
  logic               level_at_max;
  logic               tick_slow_now;
  logic               tick_slow_dly;
  logic               unused_score;

  // Slow divider ignores game state so the player can still restart.
  game_tick_scheduler_tick_divider #(
    .N (DIV_SLOW)
  ) u_slow_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (frame_pulse),
    .tick     (tick_slow_now),
    .tick_dly (tick_slow_dly)
  );

  assign step             = STEP_W'(BASE_STEP) + STEP_W'(STEP_INC) * STEP_W'(level);
  assign acc_sum          = {1'b0, acc} + step;
  assign hundreds_changed = (score[11:8] != prev_hundreds);
  assign level_at_max     = (level == LEVEL_W'(MAX_LEVEL));
  assign unused_score     = ^{score[15:12], score[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      level         <= '0;
      prev_hundreds <= '0;
      tick_obstacle <= 1'b0;
    end else begin
      prev_hundreds <= score[11:8];
      tick_obstacle <= 1'b0;
      if (game_start_pulse) begin
        // Start wins over a coincident frame: that frame gets no obstacle phase.
        acc   <= '0;
        level <= '0;
      end else begin
        if (frame_pulse && !game_frozen) begin
          acc           <= acc_sum[ACC_W-1:0];
          tick_obstacle <= acc_sum[ACC_W];
        end
        if (hundreds_changed && !game_frozen && !level_at_max) begin
          level <= level + LEVEL_W'(1);
        end
      end
    end
  end

  assign tick_slow   = {tick_slow_dly, tick_slow_now};
  assign speed_level = level;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler against a frame/phase model.
module tb_game_tick_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_pulse = 1'b0;
  logic        game_start_pulse = 1'b0;
  logic        game_frozen = 1'b0;
  logic [15:0] score = 16'h0000;
  logic [1:0]  tick_slow;
  logic        tick_obstacle;
  logic [2:0]  speed_level;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: frames counted since reset, obstacle phase in 64ths.
  int m_frames, m_phase, m_lvl, m_prev;
  bit m_s0, m_s1, m_obs;

  game_tick_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_pulse      (frame_pulse),
    .game_start_pulse (game_start_pulse),
    .game_frozen      (game_frozen),
    .score            (score),
    .tick_slow        (tick_slow),
    .tick_obstacle    (tick_obstacle),
    .speed_level      (speed_level)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] got_v();
    return {tick_slow, tick_obstacle, speed_level};
  endfunction

  function automatic logic [5:0] exp_v();
    logic [2:0] l;
    l = 3'(m_lvl);
    return {m_s1, m_s0, m_obs, l};
  endfunction

  task automatic model_reset();
    m_frames = 0; m_phase = 0; m_lvl = 0; m_prev = 0;
    m_s0 = 0; m_s1 = 0; m_obs = 0;
  endtask

  // Drive one cycle of inputs (frozen/score taken from current values),
  // advance the model, then wait to 1 ns past the edge.
  task automatic cycle(input bit f, input bit st);
    frame_pulse      = f;
    game_start_pulse = st;
    m_s1 = m_s0;
    m_s0 = 0;
    if (f) begin
      m_frames++;
      m_s0 = (m_frames % 3 == 0);
    end
    m_obs = 0;
    if (st) m_phase = 0;
    else if (f && !game_frozen) begin
      m_phase += 32 + 4 * m_lvl;
      if (m_phase >= 64) begin
        m_obs = 1;
        m_phase -= 64;
      end
    end
    if (st) m_lvl = 0;
    else if (!game_frozen && int'(score[11:8]) != m_prev) m_lvl = (m_lvl < 7) ? m_lvl + 1 : 7;
    m_prev = int'(score[11:8]);
    @(posedge clk);
    #1;
    frame_pulse      = 1'b0;
    game_start_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (got_v() !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b exp=%b", got_v(), 6'b0);
    end
    rst_n = 1'b1;
    model_reset();
    cycle(0, 0);
    tests_run++;
    if (got_v() !== exp_v()) begin
      tests_failed++;
      $display("FAIL reset_release got=%b exp=%b", got_v(), exp_v());
    end
  endtask

  task automatic test_slow_divider();
    int n_s0 = 0, n_s1 = 0, n_obs = 0;
    game_frozen = 0;
    score = 16'h0000;
    for (int k = 1; k <= 9; k++) begin
      for (int c = 0; c < 100; c++) begin
        cycle(c == 0, 0);
        n_s0 += int'(tick_slow[0]);
        n_s1 += int'(tick_slow[1]);
        n_obs += int'(tick_obstacle);
        tests_run++;
        if (got_v() !== exp_v()) begin
          tests_failed++;
          $display("FAIL slow_div frame=%0d c=%0d got=%b exp=%b", k, c, got_v(), exp_v());
        end
      end
    end
    tests_run++;
    if (n_s0 != 3 || n_s1 != 3 || n_obs != 4) begin
      tests_failed++;
      $display("FAIL slow_div_counts got s0=%0d s1=%0d obs=%0d exp 3 3 4", n_s0, n_s1, n_obs);
    end
  endtask

  task automatic test_start();
    int first_obs = 0;
    game_frozen = 0;
    for (int h = 1; h <= 3; h++) begin
      score = 16'(h << 8);
      cycle(0, 0);
      cycle(1, 0);
      tests_run++;
      if (got_v() !== exp_v()) begin
        tests_failed++;
        $display("FAIL start_prep h=%0d got=%b exp=%b", h, got_v(), exp_v());
      end
    end
    cycle(0, 1);
    tests_run++;
    if (got_v() !== exp_v() || speed_level !== 3'd0) begin
      tests_failed++;
      $display("FAIL start_clear got=%b exp=%b", got_v(), exp_v());
    end
    for (int k = 1; k <= 4; k++) begin
      for (int c = 0; c < 5; c++) begin
        cycle(c == 0, 0);
        if (tick_obstacle && first_obs == 0) first_obs = k;
        tests_run++;
        if (got_v() !== exp_v()) begin
          tests_failed++;
          $display("FAIL start_frames k=%0d got=%b exp=%b", k, got_v(), exp_v());
        end
      end
    end
    tests_run++;
    if (first_obs != 2) begin
      tests_failed++;
      $display("FAIL start_first_obs got=%0d exp=2", first_obs);
    end
  endtask

  task automatic test_level_saturation();
    int n_obs = 0;
    game_frozen = 0;
    score = 16'h0099;
    cycle(0, 1);
    for (int h = 1; h <= 9; h++) begin
      score = 16'(h << 8);
      cycle(0, 0);
      tests_run++;
      if (got_v() !== exp_v() || speed_level !== 3'((h < 7) ? h : 7)) begin
        tests_failed++;
        $display("FAIL level_step h=%0d got=%b exp=%b", h, got_v(), exp_v());
      end
    end
    for (int k = 0; k < 128; k++) begin
      cycle(k % 2 == 0, 0);
      n_obs += int'(tick_obstacle);
      tests_run++;
      if (got_v() !== exp_v()) begin
        tests_failed++;
        $display("FAIL level_max_frames k=%0d got=%b exp=%b", k, got_v(), exp_v());
      end
    end
    tests_run++;
    if (n_obs != 60) begin
      tests_failed++;
      $display("FAIL level7_rate got=%0d exp=60", n_obs);
    end
  endtask

  task automatic test_frozen();
    int n_s0 = 0, n_s1 = 0, n_obs = 0;
    game_frozen = 1;
    score = 16'h0100;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) score = 16'h0200;
      for (int c = 0; c < 3; c++) begin
        cycle(c == 0, 0);
        n_s0 += int'(tick_slow[0]);
        n_s1 += int'(tick_slow[1]);
        n_obs += int'(tick_obstacle);
        tests_run++;
        if (got_v() !== exp_v()) begin
          tests_failed++;
          $display("FAIL frozen k=%0d c=%0d got=%b exp=%b", k, c, got_v(), exp_v());
        end
      end
    end
    tests_run++;
    if (n_obs != 0 || n_s0 != 4 || n_s1 != 4) begin
      tests_failed++;
      $display("FAIL frozen_counts got obs=%0d s0=%0d s1=%0d exp 0 4 4", n_obs, n_s0, n_s1);
    end
    game_frozen = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(c % 3 == 0, 0);
      tests_run++;
      if (got_v() !== exp_v()) begin
        tests_failed++;
        $display("FAIL unfreeze c=%0d got=%b exp=%b", c, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_start_with_frame();
    game_frozen = 0;
    score = 16'h0000;
    cycle(0, 1);
    cycle(0, 0);
    score = 16'h0100;
    cycle(0, 0);
    score = 16'h0200;
    cycle(0, 0);
    cycle(1, 0);
    cycle(1, 1);
    tests_run++;
    if (got_v() !== exp_v() || tick_obstacle !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_and_frame got=%b exp=%b", got_v(), exp_v());
    end
    for (int c = 0; c < 12; c++) begin
      cycle(c % 3 == 0, 0);
      tests_run++;
      if (got_v() !== exp_v()) begin
        tests_failed++;
        $display("FAIL after_start_frame c=%0d got=%b exp=%b", c, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_random();
    bit f, st;
    for (int c = 0; c < 1500; c++) begin
      f  = ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 49) == 0) game_frozen = ~game_frozen;
      if ($urandom_range(0, 15) == 0) score = 16'($urandom_range(0, 9) << 8) | 16'($urandom_range(0, 99));
      cycle(f, st);
      tests_run++;
      if (got_v() !== exp_v()) begin
        tests_failed++;
        $display("FAIL random c=%0d got=%b exp=%b", c, got_v(), exp_v());
      end
    end
    game_frozen = 0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle(c % 4 == 0, 0);
      tests_run++;
      if (got_v() !== exp_v()) begin
        tests_failed++;
        $display("FAIL reset_mid_pre c=%0d got=%b exp=%b", c, got_v(), exp_v());
      end
      if (tick_slow[0] === 1'b1) found = 1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL reset_mid_wait got=no tick_slow[0] exp=tick within 40 cycles");
    end else begin
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (got_v() !== 6'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_async got=%b exp=%b", got_v(), 6'b0);
      end
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        tests_run++;
        if (tick_slow !== 2'b00) begin
          tests_failed++;
          $display("FAIL reset_mid_hold c=%0d got=%b exp=00", c, tick_slow);
        end
      end
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 8; c++) begin
        cycle(c % 2 == 0, 0);
        tests_run++;
        if (got_v() !== exp_v()) begin
          tests_failed++;
          $display("FAIL reset_mid_after c=%0d got=%b exp=%b", c, got_v(), exp_v());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_slow_divider();
    test_start();
    test_level_saturation();
    test_frozen();
    test_start_with_frame();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
